// File: rtl/add_arbiter_if.sv
// Bundle of request, adder and response signals shared by add_arbiter and its surroundings.
// The arbiter sits on the slave modport; the requester/adder/consumer side uses master.
interface add_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic [8:0]        add_c;
  logic              add_v;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_c;
  logic              rsp_err;
  logic              rsp_ready;

  modport master (
    output req_valid, req_a, req_b, add_c, add_v, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_c, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, add_c, add_v, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_c, rsp_err
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one registered 8-bit adder among NREQ requesters,
// one operation in flight, results returned on a single tagged response channel.
module add_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic         clk,
  input  logic         rst,
  add_arbiter_if.slave bus,
  output logic         busy,
  output logic [15:0]  op_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StCollect, StResp} state_e;

  state_e         state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] winner;
  logic           found;
  int unsigned    idx;
  logic [7:0]     win_a;
  logic [7:0]     win_b;

  // Search starts just after the last grant and wraps, giving rotating priority.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_grant_q) + i) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && found) bus.req_ready[winner] = 1'b1;
  end

  assign win_a = bus.req_a[8*winner +: 8];
  assign win_b = bus.req_b[8*winner +: 8];
  assign busy  = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= IDW'(NREQ - 1);
      id_q          <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_c     <= '0;
      bus.rsp_err   <= 1'b0;
      op_cnt        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            bus.add_a    <= win_a;
            bus.add_b    <= win_b;
            id_q         <= winner;
            last_grant_q <= winner;
            state_q      <= StIssue;
          end
        end
        StIssue: state_q <= StCollect;
        StCollect: begin
          bus.rsp_c     <= bus.add_c;
          bus.rsp_err   <= ~bus.add_v;
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
          state_q       <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            op_cnt        <= op_cnt + 16'd1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: a registered adder model, a table of single operations,
// and hand-written sequences for round-robin streaming, backpressure, reset abort and add_v errors.
module tb_add_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_n;
  logic        force_v0 = 1'b0;
  logic        busy;
  logic [15:0] op_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  er;
    int          id;
    int          c;
  } vec_t;

  vec_t vt[7];

  add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .op_cnt (op_cnt)
  );

  always #5 clk = ~clk;
  assign rst_n = ~rst;

  // Adder model: 1-cycle registered 9-bit sum with a valid flag that can be forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_c <= '0;
      bus.add_v <= 1'b0;
    end else begin
      bus.add_c <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
      bus.add_v <= ~force_v0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    force_v0      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = 0;
  endtask

  // One complete operation; call at #1 after a rising edge with the arbiter idle.
  task automatic do_op(input string nm, input logic [3:0] v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] er, input int eid,
                       input int ec, input logic ee);
    int n;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = 1'b1;
    #1;
    check({nm, " req_ready"}, 32'(bus.req_ready), 32'(er));
    @(posedge clk); #1;
    bus.req_valid = '0;
    check({nm, " busy"}, 32'(busy), 1);
    check({nm, " add_a"}, 32'(bus.add_a), 32'(a[8*eid +: 8]));
    wait_rsp(n);
    check({nm, " latency"}, n, 2);
    check({nm, " rsp_id"}, 32'(bus.rsp_id), eid);
    check({nm, " rsp_c"}, 32'(bus.rsp_c), ec);
    check({nm, " rsp_err"}, 32'(bus.rsp_err), 32'(ee));
    @(posedge clk); #1;
    exp_cnt++;
    check({nm, " op_cnt"}, 32'(op_cnt), exp_cnt);
    check({nm, " rsp_valid drop"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    int n;
    int got;
    int last;
    int seen;
    int ids[5];

    ids = '{0, 1, 2, 3, 0};
    // Grant chain from reset: last_grant starts at 3.
    vt[0] = '{4'b0001, 32'h0000_0003, 32'h0000_0004, 4'b0001, 0, 7};
    vt[1] = '{4'b1111, 32'hFF1E_140A, 32'hFF03_0201, 4'b0010, 1, 22};
    vt[2] = '{4'b1001, 32'hFF1E_140A, 32'hFF03_0201, 4'b1000, 3, 510};
    vt[3] = '{4'b0011, 32'h0000_0000, 32'h0000_0000, 4'b0001, 0, 0};
    vt[4] = '{4'b0100, 32'h0064_0000, 32'h00C8_0000, 4'b0100, 2, 300};
    vt[5] = '{4'b1010, 32'h8000_0000, 32'h7F00_0000, 4'b1000, 3, 255};
    vt[6] = '{4'b0110, 32'h0000_0100, 32'h0000_FF00, 4'b0010, 1, 256};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(bus.req_ready), 0);
    check("reset add_a", 32'(bus.add_a), 0);
    check("reset add_b", 32'(bus.add_b), 0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset rsp_id", 32'(bus.rsp_id), 0);
    check("reset rsp_c", 32'(bus.rsp_c), 0);
    check("reset rsp_err", 32'(bus.rsp_err), 0);
    check("reset busy", 32'(busy), 0);
    check("reset op_cnt", 32'(op_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vt[i].v, vt[i].a, vt[i].b, vt[i].er, vt[i].id, vt[i].c, 1'b0);

    // All four requesters held valid: order 0,1,2,3,0, one response every 4 cycles.
    do_reset();
    bus.req_a     = 32'h2319_0F05;
    bus.req_b     = 32'h0403_0201;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    got  = 0;
    last = 0;
    for (int cyc = 1; cyc <= 40 && got < 5; cyc++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        check("rr rsp_id", 32'(bus.rsp_id), ids[got]);
        check("rr rsp_c", 32'(bus.rsp_c), ids[got] * 11 + 6);
        if (got > 0) check("rr spacing", cyc - last, 4);
        last = cyc;
        got++;
        if (got == 5) bus.req_valid = '0;
      end
    end
    check("rr response count", got, 5);
    @(posedge clk); #1;
    check("rr op_cnt", 32'(op_cnt), 5);

    // Backpressure: response held 10 cycles while req2 waits.
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_a     = 32'd50;
    bus.req_b     = 32'd60;
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    bus.req_a     = 32'h0007_0000;
    bus.req_b     = 32'h0008_0000;
    wait_rsp(n);
    check("bp latency", n, 2);
    for (int k = 0; k < 10; k++) begin
      check("bp hold {valid,ready,c,add_a}",
            {10'b0, bus.rsp_valid, bus.req_ready, bus.rsp_c, bus.add_a},
            {10'b0, 1'b1, 4'b0000, 9'd110, 8'd50});
      @(posedge clk); #1;
    end
    check("bp op_cnt held", 32'(op_cnt), 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp op_cnt after handshake", 32'(op_cnt), 1);
    check("bp busy after handshake", 32'(busy), 0);
    check("bp req_ready after handshake", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("bp req2 add_a", 32'(bus.add_a), 7);
    check("bp req2 busy", 32'(busy), 1);
    wait_rsp(n);
    check("bp req2 latency", n, 2);
    check("bp req2 rsp_id", 32'(bus.rsp_id), 2);
    check("bp req2 rsp_c", 32'(bus.rsp_c), 15);
    @(posedge clk); #1;
    check("bp req2 op_cnt", 32'(op_cnt), 2);

    // Reset asserted mid-cycle while in COLLECT.
    bus.req_a     = 32'h0B00_0000;
    bus.req_b     = 32'h1600_0000;
    bus.req_valid = 4'b1000;
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("abort busy before", 32'(busy), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort rsp_valid", 32'(bus.rsp_valid), 0);
    check("abort op_cnt", 32'(op_cnt), 0);
    check("abort add_a", 32'(bus.add_a), 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    exp_cnt = 0;
    seen    = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1;
    end
    check("abort no response", seen, 0);
    do_op("abort prio", 4'b0011, 32'h0000_0201, 32'h0000_0302, 4'b0001, 0, 3, 1'b0);

    // Adder valid flag forced low during the operation.
    force_v0 = 1'b1;
    do_op("add_v low", 4'b0001, 32'd9, 32'd8, 4'b0001, 0, 17, 1'b1);
    force_v0 = 1'b0;
    do_op("add_v high", 4'b0001, 32'd200, 32'd100, 4'b0001, 0, 300, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
